// File: rtl/sum_frame_packer_if.sv
// Summer-result capture inputs and framed byte-stream outputs of sum_frame_packer.
// slave = the packer itself, master = the environment driving it.
interface sum_frame_packer_if #(
    parameter int DEPTH = 4
);
    logic [16:0]              sum_in;
    logic                     sum_enable;
    logic [7:0]               out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     overflow;
    logic                     clr_overflow;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport slave (
        input  sum_in, sum_enable, out_ready, clr_overflow,
        output out_data, out_valid, overflow, fifo_count
    );

    modport master (
        output sum_in, sum_enable, out_ready, clr_overflow,
        input  out_data, out_valid, overflow, fifo_count
    );
endinterface

// File: rtl/sum_frame_packer.sv
// Queues 17-bit summer results and streams each as a 5-byte {hdr|seq, sum, avg} frame; first byte valid 2 edges after strobe.
// Backpressure: out_data/out_valid hold until out_ready; a full queue drops new sums and sets sticky overflow.
module sum_frame_packer #(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] HEADER = 4'hA
) (
    input logic               CLK,
    input logic               RST,
    sum_frame_packer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]  seq;
        logic [16:0] sum;
    } entry_t;

    typedef enum logic {IDLE, SEND} state_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [3:0]      seq;
    state_t          state;
    entry_t          frame;
    logic [2:0]      idx;
    logic [7:0]      out_data_q;
    logic            out_valid_q;
    logic            overflow_q;
    logic            hs, last_hs, pop, push, drop;

    function automatic logic [7:0] frame_byte(entry_t e, logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = {HEADER, e.seq};
            3'd1:    b = {7'h00, e.sum[16]};
            3'd2:    b = e.sum[15:8];
            3'd3:    b = e.sum[7:0];
            default: b = (e.sum[16:15] != 2'b00) ? 8'hFF : e.sum[14:7];
        endcase
        return b;
    endfunction

    // The final-byte handshake pops the next entry in the same edge, so frames run back-to-back.
    always_comb begin
        hs      = (state == SEND) && bus.out_ready;
        last_hs = hs && (idx == 3'd4);
        pop     = (count != '0) && ((state == IDLE) || last_hs);
        push    = bus.sum_enable && ((count != CW'(DEPTH)) || pop);
        drop    = bus.sum_enable && !push;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {seq, bus.sum_in};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + 4'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            frame       <= '0;
            idx         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (pop) begin
            frame       <= mem[rd_ptr];
            idx         <= '0;
            out_data_q  <= frame_byte(mem[rd_ptr], 3'd0);
            out_valid_q <= 1'b1;
            state       <= SEND;
        end else if (hs) begin
            if (idx != 3'd4) begin
                idx        <= idx + 3'd1;
                out_data_q <= frame_byte(frame, idx + 3'd1);
            end else begin
                state       <= IDLE;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = count;
endmodule

// File: tb/tb_sum_frame_packer.sv
// Randomized and directed checks of sum_frame_packer against a queue-based frame model.
module tb_sum_frame_packer;
    localparam int DEPTH = 4;

    logic CLK;
    logic RST;
    sum_frame_packer_if #(.DEPTH(DEPTH)) bus ();

    sum_frame_packer #(.DEPTH(DEPTH), .HEADER(4'hA)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         q[$];
    bit         m_inflight;
    int         m_cur, m_idx, m_seq;
    bit         m_ovf;
    logic [7:0] rx[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte i of the frame for an entry packed as seq<<17 | sum.
    function automatic int exp_byte(int e, int i);
        int s, v, a;
        s = (e >> 17) & 15;
        v = e & 'h1FFFF;
        case (i)
            0:       return 'hA0 | s;
            1:       return v >> 16;
            2:       return (v >> 8) & 255;
            3:       return v & 255;
            default: begin
                a = v / 128;
                return (a > 255) ? 255 : a;
            end
        endcase
    endfunction

    function automatic logic [39:0] frame40(int e);
        logic [39:0] r;
        r = '0;
        for (int j = 0; j < 5; j++) r = {r[31:0], 8'(exp_byte(e, j))};
        return r;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_inflight = 0;
        m_idx      = 0;
        m_seq      = 0;
        m_ovf      = 0;
        m_cur      = 0;
    endfunction

    function automatic void model_edge();
        bit hs, pop, push;
        hs   = m_inflight && bus.out_ready;
        pop  = (q.size() > 0) && (!m_inflight || (hs && m_idx == 4));
        push = bus.sum_enable && ((q.size() < DEPTH) || pop);
        if (hs) begin
            if (m_idx < 4) m_idx++;
            else m_inflight = 0;
        end
        if (pop) begin
            m_cur      = q.pop_front();
            m_idx      = 0;
            m_inflight = 1;
        end
        if (push) begin
            q.push_back((m_seq << 17) | int'(bus.sum_in));
            m_seq = (m_seq + 1) % 16;
        end
        if (bus.sum_enable && !push) m_ovf = 1;
        else if (bus.clr_overflow) m_ovf = 0;
    endfunction

    // Called at a falling edge; advances one clock and checks outputs at the next falling edge.
    task automatic step();
        bit         hs_dut;
        logic [7:0] b;
        hs_dut = bus.out_valid && bus.out_ready;
        b      = bus.out_data;
        @(posedge CLK);
        model_edge();
        if (hs_dut) rx.push_back(b);
        @(negedge CLK);
        check("out_valid", bus.out_valid, m_inflight);
        if (m_inflight) check("out_data", bus.out_data, exp_byte(m_cur, m_idx));
        check("fifo_count", bus.fifo_count, q.size());
        check("overflow", bus.overflow, m_ovf);
    endtask

    task automatic pulse(int s);
        bus.sum_in     = 17'(s);
        bus.sum_enable = 1'b1;
        step();
        bus.sum_enable = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_inflight || q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check("drain_done", (m_inflight || q.size() != 0), 0);
    endtask

    task automatic wait_idx(int t);
        int n;
        n = 0;
        while (!(m_inflight && m_idx == t) && n < 100) begin
            step();
            n++;
        end
        check("wait_idx", (m_inflight && m_idx == t), 1);
    endtask

    task automatic get_frame(string tag, logic [39:0] exp);
        logic [39:0] got;
        if (rx.size() < 5) begin
            check(tag, rx.size(), 5);
            rx.delete();
        end else begin
            got = '0;
            for (int j = 0; j < 5; j++) got = {got[31:0], rx.pop_front()};
            check(tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        rx.delete();
    endtask

    initial begin
        int gaps;
        RST              = 1'b0;
        bus.sum_in       = '0;
        bus.sum_enable   = 1'b0;
        bus.out_ready    = 1'b0;
        bus.clr_overflow = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_ovf", bus.overflow, 0);
        check("rst_count", bus.fifo_count, 0);
        RST = 1'b1;

        // Single frame and first-byte latency
        bus.out_ready = 1'b1;
        pulse('h07F80);
        check("lat_T", bus.out_valid, 0);
        step();
        check("lat_T1", bus.out_valid, 1);
        check("lat_B0", bus.out_data, 8'hA0);
        drain();
        get_frame("frame_07F80", 40'hA0_00_7F_80_FF);
        check("idle_valid", bus.out_valid, 0);
        check("idle_count", bus.fifo_count, 0);

        // Saturated and unsaturated averages
        do_reset();
        bus.out_ready = 1'b1;
        pulse('h12345);
        drain();
        pulse('h00400);
        drain();
        get_frame("frame_12345", 40'hA0_01_23_45_FF);
        get_frame("frame_00400", 40'hA1_00_04_00_08);

        // Backpressure while B2 is presented
        pulse('h07F80);
        wait_idx(2);
        bus.out_ready = 1'b0;
        repeat (3) begin
            step();
            check("bp_data", bus.out_data, 8'h7F);
            check("bp_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        drain();
        get_frame("frame_bp", 40'hA2_00_7F_80_FF);
        check("bp_rx_empty", rx.size(), 0);

        // Overflow and back-to-back frames
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            bus.sum_in     = 17'(k);
            bus.sum_enable = 1'b1;
            step();
        end
        bus.sum_enable = 1'b0;
        check("ovf_count", bus.fifo_count, 4);
        check("ovf_flag", bus.overflow, 1);
        bus.out_ready = 1'b1;
        gaps = 0;
        repeat (25) begin
            if (!bus.out_valid) gaps++;
            step();
        end
        check("b2b_gaps", gaps, 0);
        check("b2b_end_valid", bus.out_valid, 0);
        for (int k = 0; k < 5; k++)
            get_frame("ovf_frame", {8'hA0 | 8'(k), 8'h00, 8'h00, 8'(k + 1), 8'h00});
        check("ovf_sticky", bus.overflow, 1);
        bus.clr_overflow = 1'b1;
        step();
        bus.clr_overflow = 1'b0;
        check("ovf_clear", bus.overflow, 0);

        // Sequence wrap with random sums
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            int s;
            s = int'($urandom_range(0, 'h1FFFF));
            pulse(s);
            drain();
            get_frame("wrap_frame", frame40(((i % 16) << 17) | s));
        end

        // Reset in the middle of a frame
        do_reset();
        bus.out_ready = 1'b1;
        pulse('h00100);
        pulse('h00200);
        pulse('h00300);
        wait_idx(2);
        RST = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_count", bus.fifo_count, 0);
        check("midrst_data", bus.out_data, 8'h00);
        @(negedge CLK);
        RST = 1'b1;
        rx.delete();
        pulse('h00080);
        drain();
        get_frame("midrst_frame", 40'hA0_00_00_80_01);

        // Random traffic with backpressure, drops and clears
        for (int c = 0; c < 2000; c++) begin
            bus.sum_enable   = ($urandom_range(0, 9) < 3);
            bus.sum_in       = 17'($urandom_range(0, 'h1FFFF));
            bus.out_ready    = ($urandom_range(0, 9) < 6);
            bus.clr_overflow = ($urandom_range(0, 19) == 0);
            step();
        end
        bus.sum_enable   = 1'b0;
        bus.clr_overflow = 1'b0;
        bus.out_ready    = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
